// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree, one register stage per select bit (LSB first).
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_sel, out_valid/out_ready/out_data/out_err.
module mux_tree_pipe #(
  parameter int WIDTH = 8,
  parameter int NUM_IN = 8,
  parameter int SEL_W = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0] DEFAULT = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);

  localparam int LEVELS = SEL_W;
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Level 0 is the combinational leaf vector; levels 1..LEVELS are registered.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int NE = 2 ** (LEVELS - k);
    localparam int RW = LEVELS - k;

    logic [NE-1:0][WIDTH-1:0] data;
    logic                     err;
    logic                     vld;

    // Select bits still to be consumed by later levels.
    if (RW > 0) begin : g_sel
      logic [RW-1:0] sel;
      if (k == 0) begin : g_src
        assign sel = in_sel;
      end else begin : g_reg
        logic [RW-1:0] sel_d;
        logic [RW-1:0] sel_q;

        always_comb begin
          sel_d = sel_q;
          if (en) sel_d = g_lvl[k-1].g_sel.sel[RW:1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sel_q <= '0;
          else        sel_q <= sel_d;
        end

        assign sel = sel_q;
      end
    end

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < NE; i++) begin : g_ent
        if (i < NUM_IN) begin : g_in
          assign data[i] = in_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
          assign data[i] = DEFAULT;
        end
      end
      assign err = {1'b0, in_sel} >= NUM_IN_W;
      assign vld = in_valid;
    end else begin : g_stg
      logic [NE-1:0][WIDTH-1:0] data_d;
      logic [NE-1:0][WIDTH-1:0] data_q;
      logic                     err_d;
      logic                     err_q;
      logic                     vld_d;
      logic                     vld_q;

      always_comb begin
        data_d = data_q;
        err_d  = err_q;
        vld_d  = vld_q;
        if (en) begin
          for (int i = 0; i < NE; i++) begin
            data_d[i] = g_lvl[k-1].g_sel.sel[0]
                      ? g_lvl[k-1].data[2*i+1]
                      : g_lvl[k-1].data[2*i];
          end
          err_d = g_lvl[k-1].err;
          vld_d = g_lvl[k-1].vld;
          // Out-of-range select forces DEFAULT at the last level.
          if (k == LEVELS && g_lvl[k-1].err) data_d[0] = DEFAULT;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          err_q  <= 1'b0;
          vld_q  <= 1'b0;
        end else begin
          data_q <= data_d;
          err_q  <= err_d;
          vld_q  <= vld_d;
        end
      end

      assign data = data_q;
      assign err  = err_q;
      assign vld  = vld_q;
    end
  end

  assign out_data  = g_lvl[LEVELS].data[0];
  assign out_err   = g_lvl[LEVELS].err;
  assign out_valid = g_lvl[LEVELS].vld;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: tables, hand sequences, random stream.
// Main build NUM_IN=5; extra NUM_IN=2 and NUM_IN=8 builds.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [39:0] in_data;
  logic [2:0]  in_sel;
  logic [7:0]  out_data;

  logic        v8, rdy8, ov8, or8, oe8;
  logic [63:0] data8;
  logic [2:0]  sel8;
  logic [7:0]  od8;

  logic        v2, rdy2, ov2, or2, oe2;
  logic [15:0] data2;
  logic [0:0]  sel2;
  logic [7:0]  od2;

  mux_tree_pipe #(.WIDTH(8), .NUM_IN(5), .DEFAULT(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  mux_tree_pipe #(.WIDTH(8), .NUM_IN(8), .DEFAULT(8'hA5)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8),
    .in_data(data8), .in_sel(sel8),
    .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .out_err(oe8)
  );

  mux_tree_pipe #(.WIDTH(8), .NUM_IN(2), .DEFAULT(8'hA5)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(rdy2),
    .in_data(data2), .in_sel(sel2),
    .out_valid(ov2), .out_ready(or2),
    .out_data(od2), .out_err(oe2)
  );

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] d;
    logic       e;
  } vec_t;

  exp_t       q[$];
  vec_t       tbl[6];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         n_out = 0;
  int         last_lat = 0;
  logic [7:0] last_d = '0;
  logic       last_e = 1'b0;
  bit         chk_lat = 1'b0;
  bit         was_st = 1'b0;
  logic [7:0] held_d = '0;
  logic       held_e = 1'b0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: pick input sel, or DEFAULT with err when sel is past the inputs.
  function automatic exp_t model(input logic [2:0] s, input logic [39:0] d);
    exp_t x;
    x.cyc = 0;
    if (int'(s) < 5) begin
      x.d = 8'(d >> (8 * int'(s)));
      x.e = 1'b0;
    end else begin
      x.d = 8'hA5;
      x.e = 1'b1;
    end
    return x;
  endfunction

  // Called at a negedge: drive, monitor, advance one cycle.
  task automatic step(input logic v, input logic [2:0] s,
                      input logic [39:0] d, input logic r, output bit acc);
    exp_t x;
    in_valid = v;
    in_sel = s;
    in_data = d;
    out_ready = r;
    #1;
    if (was_st) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'(held_d));
      chk("hold_err", 64'(out_err), 64'(held_e));
    end
    was_st = out_valid && !out_ready;
    held_d = out_data;
    held_e = out_err;
    if (out_valid && !out_ready) chk("stall_ready", 64'(in_ready), 64'd0);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious: out_data=%0h with nothing pending", out_data);
      end else begin
        x = q.pop_front();
        chk("data", 64'(out_data), 64'(x.d));
        chk("err", 64'(out_err), 64'(x.e));
        last_lat = cyc - x.cyc;
        last_d = out_data;
        last_e = out_err;
        n_out++;
        if (chk_lat) chk("latency", 64'(last_lat), 64'd3);
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      x = model(s, d);
      x.cyc = cyc;
      q.push_back(x);
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] base;
    bit          acc;
    int          n0;
    int          sent;
    int          stalls;
    int          l2;
    int          l8;

    base = 40'h4433221100;
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = 1'b1;
    v8 = 1'b0; sel8 = '0; data8 = '0; or8 = 1'b1;
    v2 = 1'b0; sel2 = '0; data2 = '0; or2 = 1'b1;

    tbl[0] = '{sel: 3'd3, d: 8'h33, e: 1'b0};
    tbl[1] = '{sel: 3'd6, d: 8'hA5, e: 1'b1};
    tbl[2] = '{sel: 3'd4, d: 8'h44, e: 1'b0};
    tbl[3] = '{sel: 3'd7, d: 8'hA5, e: 1'b1};
    tbl[4] = '{sel: 3'd0, d: 8'h00, e: 1'b0};
    tbl[5] = '{sel: 3'd5, d: 8'hA5, e: 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid8", 64'(ov8), 64'd0);
    chk("rst_valid2", 64'(ov2), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single samples, including out-of-range selects.
    chk_lat = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n0 = n_out;
      step(1'b1, tbl[i].sel, base, 1'b1, acc);
      chk("accept", 64'(acc), 64'd1);
      for (int c = 0; c < 8 && n_out == n0; c++) step(1'b0, 3'd0, base, 1'b1, acc);
      chk("got_out", 64'(n_out - n0), 64'd1);
      chk("tbl_data", 64'(last_d), 64'(tbl[i].d));
      chk("tbl_err", 64'(last_e), 64'(tbl[i].e));
      chk("one_cycle", 64'(out_valid), 64'd0);
    end

    // Back-to-back stream.
    n0 = n_out;
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 3'(s), base, 1'b1, acc);
      chk("stream_ready", 64'(acc), 64'd1);
    end
    for (int c = 0; c < 10 && n_out < n0 + 5; c++) step(1'b0, 3'd0, base, 1'b1, acc);
    chk("stream_count", 64'(n_out - n0), 64'd5);

    // Backpressure: 5-cycle stall once the first result appears.
    chk_lat = 1'b0;
    n0 = n_out;
    sent = 0;
    stalls = -1;
    for (int c = 0; c < 40 && n_out < n0 + 5; c++) begin
      if (out_valid && stalls < 0) stalls = 5;
      if (stalls > 0 && out_valid) chk("bp_hold00", 64'(out_data), 64'h00);
      step(sent < 5, 3'(sent), base, !(stalls > 0), acc);
      if (acc) sent++;
      if (stalls > 0) stalls--;
    end
    chk("bp_count", 64'(n_out - n0), 64'd5);
    chk("bp_stalled", 64'(stalls), 64'd0);

    // Reset with three samples in flight.
    step(1'b1, 3'd1, base, 1'b1, acc);
    step(1'b1, 3'd3, base, 1'b1, acc);
    step(1'b1, 3'd4, base, 1'b1, acc);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_err", 64'(out_err), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    q.delete();
    was_st = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b0, 3'd0, base, 1'b1, acc);
    chk_lat = 1'b1;
    n0 = n_out;
    step(1'b1, 3'd2, base, 1'b1, acc);
    for (int c = 0; c < 8 && n_out == n0; c++) step(1'b0, 3'd0, base, 1'b1, acc);
    chk("post_rst_count", 64'(n_out - n0), 64'd1);
    chk("post_rst_data", 64'(last_d), 64'h22);

    // Random traffic against the model.
    chk_lat = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           {$urandom, 8'($urandom)}, $urandom_range(0, 3) != 0, acc);
    end
    for (int c = 0; c < 10; c++) step(1'b0, 3'd0, base, 1'b1, acc);
    chk("drained", 64'(q.size()), 64'd0);

    // NUM_IN=2 and NUM_IN=8 builds: select sweep.
    data8 = 64'h7766554433221100;
    data2 = 16'h1100;
    for (int s = 0; s < 8; s++) begin
      sel8 = 3'(s);
      sel2 = 1'(s);
      v8 = 1'b1;
      v2 = 1'b1;
      @(negedge clk);
      v8 = 1'b0;
      v2 = 1'b0;
      l2 = 0;
      l8 = 0;
      for (int c = 1; c <= 6; c++) begin
        if (ov2 && l2 == 0) begin
          l2 = c;
          chk("n2_data", 64'(od2), 64'(8'(17 * (s % 2))));
          chk("n2_err", 64'(oe2), 64'd0);
        end
        if (ov8 && l8 == 0) begin
          l8 = c;
          chk("n8_data", 64'(od8), 64'(8'(17 * s)));
          chk("n8_err", 64'(oe8), 64'd0);
        end
        @(negedge clk);
      end
      chk("n2_lat", 64'(l2), 64'd1);
      chk("n8_lat", 64'(l8), 64'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
